// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave family.
// Contents: HTRANS / HSIZE / HRESP bus codes and the slave FSM state encoding.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahbl_sram_ws_if.sv
// AHB-Lite slave-side bus bundle for ahbl_sram_ws.
// master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA,
//                 observes HREADYOUT/HRESP/HRDATA.
// slave modport:  the reverse.
interface ahbl_sram_ws_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_sram_mem.sv
// DEPTH x 32-bit storage with per-byte write strobes and asynchronous read.
// Ports: clk, wstrb (byte-lane enables), widx/wdata (write), ridx/rdata (read).
// Contents are never reset.
module ahbl_sram_mem #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/ahbl_sram_ws.sv
// AHB-Lite SRAM slave with configurable depth, wait states and ERROR response.
// Ports: HCLK, HRESETn (async active-low), bus (ahbl_sram_ws_if.slave).
// Word index is HADDR[AW+1:2]; misaligned, oversize or out-of-range transfers
// get a two-cycle ERROR with no memory access and no wait states.
module ahbl_sram_ws
    import ahbl_pkg::*;
#(
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned AW          = 11,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic           HCLK,
    input logic           HRESETn,
    ahbl_sram_ws_if.slave bus
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [3:0]  WS_INIT = WAIT_STATES[3:0];

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [3:0]    strb_q;
    logic          write_q;

    logic          accept;
    logic          legal;
    logic [AW-1:0] a_idx;
    logic [3:0]    a_strb;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;

    assign accept = bus.HSEL && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
    assign a_idx  = bus.HADDR[AW+1:2];

    // Little-endian lane selection from the address-phase size/offset.
    always_comb begin
        a_strb = 4'b0000;
        case (bus.HSIZE)
            HSIZE_BYTE: a_strb = 4'b0001 << bus.HADDR[1:0];
            HSIZE_HALF: a_strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: a_strb = 4'b1111;
            default:    a_strb = 4'b0000;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        if (bus.HSIZE > HSIZE_WORD)                           legal = 1'b0;
        if (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])          legal = 1'b0;
        if (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00) legal = 1'b0;
        if ({1'b0, a_idx} >= DEPTH_W)                         legal = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            // Any state whose cycle has HREADYOUT=1 may take a new address phase.
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            strb_q  <= 4'b0000;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= a_idx;
                strb_q  <= a_strb;
                write_q <= bus.HWRITE;
            end
        end
    end

    // Write lands on the edge that ends DATA; a read issued in that same cycle
    // sees the new word in its own data phase.
    assign mem_wstrb = (state_q == ST_DATA && write_q) ? strb_q : 4'b0000;

    ahbl_sram_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (HCLK),
        .wstrb (mem_wstrb),
        .widx  (idx_q),
        .wdata (bus.HWDATA),
        .ridx  (idx_q),
        .rdata (mem_rdata)
    );

    assign bus.HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = (state_q == ST_DATA) ? mem_rdata : 32'h0;

    logic unused_haddr;
    assign unused_haddr = ^bus.HADDR[31:AW+2];

endmodule

// File: tb/tb_ahbl_sram_ws.sv
// Directed bench for ahbl_sram_ws: one instance with no wait states (dut0) and
// one with three (dut3), sharing the address/data drive; sel3 picks which one
// is selected and observed. Each slave's HREADY is its own HREADYOUT.
module tb_ahbl_sram_ws;
    import ahbl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sel3;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    int checks;
    int errors;

    ahbl_sram_ws_if if0 ();
    ahbl_sram_ws_if if3 ();

    assign if0.HSEL   = hsel & ~sel3;
    assign if0.HADDR  = haddr;
    assign if0.HTRANS = htrans;
    assign if0.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;
    assign if0.HREADY = if0.HREADYOUT;
    assign if0.HWDATA = hwdata;

    assign if3.HSEL   = hsel & sel3;
    assign if3.HADDR  = haddr;
    assign if3.HTRANS = htrans;
    assign if3.HWRITE = hwrite;
    assign if3.HSIZE  = hsize;
    assign if3.HREADY = if3.HREADYOUT;
    assign if3.HWDATA = hwdata;

    ahbl_sram_ws #(.DEPTH(48), .AW(6), .WAIT_STATES(0)) dut0 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if0)
    );

    ahbl_sram_ws #(.DEPTH(48), .AW(6), .WAIT_STATES(3)) dut3 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if3)
    );

    logic        ordy;
    logic        oresp;
    logic [31:0] ordata;
    assign ordy   = sel3 ? if3.HREADYOUT : if0.HREADYOUT;
    assign oresp  = sel3 ? if3.HRESP     : if0.HRESP;
    assign ordata = sel3 ? if3.HRDATA    : if0.HRDATA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Single transfer with an idle following it; reports stall cycles and the
    // response/data seen in the final ready data-phase cycle.
    task automatic xfer(input logic s3, input logic [31:0] a, input logic [2:0] sz,
                        input logic wr, input logic [31:0] wd,
                        output int waits, output logic resp, output logic [31:0] rd);
        sel3 = s3; hsel = 1'b1; haddr = a; hsize = sz; hwrite = wr; htrans = HTRANS_NONSEQ;
        cycle();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        waits = 0;
        while (!ordy && waits < 40) begin
            cycle();
            waits++;
        end
        resp = oresp;
        rd   = ordata;
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sel3 = 1'b0; hsel = 1'b0; haddr = 0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 0;
        #1 rst_n = 1'b0;
        cycle(); cycle();
        for (int i = 0; i < 2; i++) begin
            sel3 = (i == 1); #1;
            checks++;
            if (ordy !== 1'b1 || oresp !== 1'b0 || ordata !== 32'h0) begin
                errors++;
                $display("FAIL reset dut%0d: rdy=%b resp=%b rdata=%h, want 1 0 00000000",
                         i * 3, ordy, oresp, ordata);
            end
        end
        sel3 = 1'b0;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_word_rw();
        int w; logic r; logic [31:0] d;
        xfer(1'b0, 32'h10, HSIZE_WORD, 1'b1, 32'hDEADBEEF, w, r, d);
        checks++;
        if (w !== 0 || r !== 1'b0) begin
            errors++; $display("FAIL word_write: waits=%0d resp=%b, want 0 0", w, r);
        end
        xfer(1'b0, 32'h10, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (w !== 0 || r !== 1'b0 || d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_read: waits=%0d resp=%b data=%h, want 0 0 deadbeef", w, r, d);
        end
        checks++;
        if (ordata !== 32'h0) begin
            errors++; $display("FAIL rdata_idle: got %h want 00000000", ordata);
        end
        // Top legal word index.
        xfer(1'b0, 32'hBC, HSIZE_WORD, 1'b1, 32'h0BC0_0BC0, w, r, d);
        xfer(1'b0, 32'hBC, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (r !== 1'b0 || d !== 32'h0BC0_0BC0) begin
            errors++; $display("FAIL last_index: resp=%b data=%h, want 0 0bc00bc0", r, d);
        end
    endtask

    task automatic test_byte_lanes();
        int w; logic r; logic [31:0] d;
        xfer(1'b0, 32'h13, HSIZE_BYTE, 1'b1, 32'hAA12_3456, w, r, d);
        xfer(1'b0, 32'h10, HSIZE_HALF, 1'b1, 32'h9A9B_5566, w, r, d);
        xfer(1'b0, 32'h10, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (d !== 32'hAAAD_5566) begin
            errors++; $display("FAIL lanes_byte3_half0: got %h want aaad5566", d);
        end
        xfer(1'b0, 32'h14, HSIZE_WORD, 1'b1, 32'h0000_0000, w, r, d);
        xfer(1'b0, 32'h16, HSIZE_HALF, 1'b1, 32'h1234_5678, w, r, d);
        xfer(1'b0, 32'h14, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (d !== 32'h1234_0000) begin
            errors++; $display("FAIL lanes_half1: got %h want 12340000", d);
        end
        xfer(1'b0, 32'h15, HSIZE_BYTE, 1'b1, 32'hFFFF_3CFF, w, r, d);
        xfer(1'b0, 32'h14, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (d !== 32'h1234_3C00) begin
            errors++; $display("FAIL lanes_byte1: got %h want 12343c00", d);
        end
    endtask

    task automatic test_wait_states();
        int w; logic r; logic [31:0] d;
        int n, got, nz; logic [31:0] d1, d2;
        xfer(1'b1, 32'h40, HSIZE_WORD, 1'b1, 32'h1234_5678, w, r, d);
        checks++;
        if (w !== 3) begin
            errors++; $display("FAIL ws_write_waits: got %0d want 3", w);
        end
        xfer(1'b1, 32'h44, HSIZE_WORD, 1'b1, 32'hCAFE_F00D, w, r, d);
        xfer(1'b1, 32'h40, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (w !== 3 || r !== 1'b0 || d !== 32'h1234_5678) begin
            errors++; $display("FAIL ws_read: waits=%0d resp=%b data=%h, want 3 0 12345678", w, r, d);
        end
        // NONSEQ then SEQ, second address held through the first data phase.
        sel3 = 1'b1; hsel = 1'b1; haddr = 32'h40; hsize = HSIZE_WORD; hwrite = 1'b0;
        htrans = HTRANS_NONSEQ;
        cycle();
        haddr = 32'h44; htrans = HTRANS_SEQ;
        n = 0; got = 0; nz = 0; d1 = 0; d2 = 0;
        while (got < 2 && n < 40) begin
            n++;
            if (ordy) begin
                got++;
                if (got == 1) d1 = ordata; else d2 = ordata;
            end else if (ordata !== 32'h0) begin
                nz++;
            end
            cycle();
            if (got >= 1) begin hsel = 1'b0; htrans = HTRANS_IDLE; end
        end
        checks++;
        if (n !== 8 || got !== 2) begin
            errors++; $display("FAIL b2b_cycles: cycles=%0d done=%0d, want 8 2", n, got);
        end
        checks++;
        if (d1 !== 32'h1234_5678 || d2 !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_data: got %h %h want 12345678 cafef00d", d1, d2);
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL rdata_in_wait: nonzero cycles=%0d want 0", nz);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [4];
        logic [2:0]  sizes [4];
        int w; logic r; logic [31:0] d;
        addrs = '{32'h41, 32'h42, 32'h40, 32'hC0};
        sizes = '{HSIZE_HALF, HSIZE_WORD, 3'b011, HSIZE_WORD};
        for (int i = 0; i < 4; i++) begin
            sel3 = 1'b1; hsel = 1'b1; haddr = addrs[i]; hsize = sizes[i]; hwrite = 1'b1;
            htrans = HTRANS_NONSEQ;
            cycle();
            hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
            checks++;
            if (ordy !== 1'b0 || oresp !== 1'b1) begin
                errors++; $display("FAIL err1_%0d: rdy=%b resp=%b, want 0 1", i, ordy, oresp);
            end
            cycle();
            checks++;
            if (ordy !== 1'b1 || oresp !== 1'b1) begin
                errors++; $display("FAIL err2_%0d: rdy=%b resp=%b, want 1 1", i, ordy, oresp);
            end
            cycle();
            checks++;
            if (ordy !== 1'b1 || oresp !== 1'b0) begin
                errors++; $display("FAIL err_after_%0d: rdy=%b resp=%b, want 1 0", i, ordy, oresp);
            end
        end
        xfer(1'b1, 32'h40, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (r !== 1'b0 || d !== 32'h1234_5678) begin
            errors++; $display("FAIL err_no_write: resp=%b data=%h, want 0 12345678", r, d);
        end
    endtask

    task automatic test_raw_and_idle();
        int w; logic r; logic [31:0] d;
        sel3 = 1'b0; hsel = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD; hwrite = 1'b1;
        htrans = HTRANS_NONSEQ;
        cycle();
        hwdata = 32'h600D_CAFE; hwrite = 1'b0;
        cycle();
        hsel = 1'b0; htrans = HTRANS_IDLE;
        checks++;
        if (ordy !== 1'b1 || ordata !== 32'h600D_CAFE) begin
            errors++; $display("FAIL raw: rdy=%b data=%h, want 1 600dcafe", ordy, ordata);
        end
        cycle();
        // IDLE then BUSY, selected and writing, must not start a data phase.
        hsel = 1'b1; hwrite = 1'b1; htrans = HTRANS_IDLE;
        cycle();
        hwdata = 32'hFFFF_FFFF; htrans = HTRANS_BUSY;
        checks++;
        if (ordy !== 1'b1 || oresp !== 1'b0) begin
            errors++; $display("FAIL idle_okay: rdy=%b resp=%b, want 1 0", ordy, oresp);
        end
        cycle();
        hsel = 1'b0; htrans = HTRANS_IDLE;
        checks++;
        if (ordy !== 1'b1 || oresp !== 1'b0) begin
            errors++; $display("FAIL busy_okay: rdy=%b resp=%b, want 1 0", ordy, oresp);
        end
        cycle();
        xfer(1'b0, 32'h20, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (d !== 32'h600D_CAFE) begin
            errors++; $display("FAIL idle_no_write: got %h want 600dcafe", d);
        end
    endtask

    task automatic test_reset_in_wait();
        int w; logic r; logic [31:0] d;
        xfer(1'b1, 32'h60, HSIZE_WORD, 1'b1, 32'h0BAD_F00D, w, r, d);
        sel3 = 1'b1; hsel = 1'b1; haddr = 32'h60; hsize = HSIZE_WORD; hwrite = 1'b1;
        htrans = HTRANS_NONSEQ;
        cycle();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h5555_AAAA;
        cycle();
        checks++;
        if (ordy !== 1'b0) begin
            errors++; $display("FAIL pre_reset_wait: rdy=%b want 0", ordy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ordy !== 1'b1 || oresp !== 1'b0 || ordata !== 32'h0) begin
            errors++; $display("FAIL async_reset: rdy=%b resp=%b data=%h, want 1 0 00000000",
                               ordy, oresp, ordata);
        end
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        xfer(1'b1, 32'h60, HSIZE_WORD, 1'b0, 32'h0, w, r, d);
        checks++;
        if (d !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL reset_drop_write: got %h want 0badf00d", d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_illegal();
        test_raw_and_idle();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
